// File: rtl/scratchpad_seq.sv
// scratchpad_seq: command-driven mover between the tensor-core matrix buffers
// and the memory arbiter's scratchpad port. LOAD commands pull ROWS 64-bit rows
// from the arbiter into a buffer; STORE commands push a buffer out to the
// arbiter, with a one-row prefetch so store_data is always ready at each hit.
// Optional feature macro: SCRATCHPAD_SEQ_ROWCHECK_EN adds the sticky row_err
// output that flags row-index disagreement and cross-request hits.
module scratchpad_seq #(
    parameter int CMD_DEPTH = 4,
    parameter int NBUF      = 4,
    parameter int ROWS      = 4,
    localparam int BUF_W    = $clog2(NBUF),
    localparam int ROW_W    = $clog2(ROWS)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [31:0]            cmd_addr,
    input  logic [BUF_W-1:0]       cmd_buf,
    output logic                   done,
    output logic                   done_op,
    output logic [BUF_W-1:0]       done_buf,
    output logic                   busy,
    output logic                   sLoad,
    output logic                   sStore,
    output logic [31:0]            load_addr,
    output logic [31:0]            store_addr,
    output logic [63:0]            store_data,
    input  logic                   sLoad_hit,
    input  logic                   sStore_hit,
    input  logic [63:0]            load_data,
    input  logic [1:0]             sLoad_row,
    output logic                   buf_wen,
    output logic [BUF_W+ROW_W-1:0] buf_waddr,
    output logic [63:0]            buf_wdata,
    output logic                   buf_ren,
    output logic [BUF_W+ROW_W-1:0] buf_raddr,
`ifdef SCRATCHPAD_SEQ_ROWCHECK_EN
    output logic                   row_err,
`endif
    input  logic [63:0]            buf_rdata
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(CMD_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_LD_WB  = 3'd2,
        S_ST_PF0 = 3'd3,
        S_ST_PF1 = 3'd4,
        S_ST     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t state_q, state_d;

    // command FIFO
    logic             fifo_op_q   [CMD_DEPTH];
    logic [31:0]      fifo_addr_q [CMD_DEPTH];
    logic [BUF_W-1:0] fifo_buf_q  [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             fifo_full_s, fifo_empty_s, push_s, pop_s;

    // latched command and datapath
    logic             op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [BUF_W-1:0] bufsel_q, bufsel_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [63:0]      next_q, next_d;
    logic             rvalid_q;

    // registered outputs
    logic             sload_q, sload_d, sstore_q, sstore_d;
    logic [31:0]      load_addr_q, load_addr_d, store_addr_q, store_addr_d;
    logic [63:0]      store_data_q, store_data_d;
    logic             wen_q, wen_d, ren_q, ren_d;
    logic [BUF_W+ROW_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic             done_q, done_d, done_op_q, done_op_d, busy_q, busy_d;
    logic [BUF_W-1:0] done_buf_q, done_buf_d;

    logic             ld_hit_s, st_hit_s, row_last_s;
    logic [ROW_W:0]   row_p2_s;
    logic [63:0]      next_val_s;

    assign fifo_full_s  = (cnt_q == FIFO_FULL);
    assign fifo_empty_s = (cnt_q == (PTR_W+1)'(0));
    assign cmd_ready    = nRST && !fifo_full_s;
    assign push_s       = cmd_valid && cmd_ready;
    assign pop_s        = (state_q == S_IDLE) && !fifo_empty_s;

    // Hits only count while the matching request is actually up.
    assign ld_hit_s   = (state_q == S_LD) && sload_q && sLoad_hit;
    assign st_hit_s   = (state_q == S_ST) && sstore_q && sStore_hit;
    assign row_last_s = (row_q == LAST_ROW);
    assign row_p2_s   = {1'b0, row_q} + (ROW_W+1)'(2);
    // A prefetched row may land in the same cycle as the hit that needs it.
    assign next_val_s = rvalid_q ? buf_rdata : next_q;

    // FIFO storage write on push (no reset needed for payload)
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_op_q[wr_ptr_q]   <= cmd_op;
            fifo_addr_q[wr_ptr_q] <= cmd_addr;
            fifo_buf_q[wr_ptr_q]  <= cmd_buf;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        else        wr_ptr_d = wr_ptr_q;
        if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else        rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) state_d = fifo_op_q[rd_ptr_q] ? S_ST_PF0 : S_LD;
                else       state_d = S_IDLE;
            end
            S_LD: begin
                if (ld_hit_s && row_last_s) state_d = S_LD_WB;
                else                        state_d = S_LD;
            end
            S_LD_WB:  state_d = S_DONE;
            S_ST_PF0: state_d = S_ST_PF1;
            S_ST_PF1: state_d = S_ST;
            S_ST: begin
                if (st_hit_s && row_last_s) state_d = S_DONE;
                else                        state_d = S_ST;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM output and datapath next values
    always_comb begin
        op_d         = op_q;
        addr_d       = addr_q;
        bufsel_d     = bufsel_q;
        row_d        = row_q;
        next_d       = next_q;
        sload_d      = sload_q;
        sstore_d     = sstore_q;
        load_addr_d  = load_addr_q;
        store_addr_d = store_addr_q;
        store_data_d = store_data_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        ren_d        = 1'b0;
        raddr_d      = raddr_q;
        done_d       = 1'b0;
        done_op_d    = done_op_q;
        done_buf_d   = done_buf_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    op_d     = fifo_op_q[rd_ptr_q];
                    addr_d   = fifo_addr_q[rd_ptr_q];
                    bufsel_d = fifo_buf_q[rd_ptr_q];
                    row_d    = {ROW_W{1'b0}};
                    if (fifo_op_q[rd_ptr_q]) begin
                        ren_d   = 1'b1;
                        raddr_d = {fifo_buf_q[rd_ptr_q], {ROW_W{1'b0}}};
                    end else begin
                        sload_d     = 1'b1;
                        load_addr_d = fifo_addr_q[rd_ptr_q];
                    end
                end else begin
                    row_d = row_q;
                end
            end
            S_LD: begin
                if (ld_hit_s) begin
                    // load_data arrives next cycle; the write strobe lines up with it
                    wen_d   = 1'b1;
                    waddr_d = {bufsel_q, row_q};
                    if (row_last_s) sload_d = 1'b0;
                    else            row_d   = row_q + ROW_W'(1);
                end else begin
                    wen_d = 1'b0;
                end
            end
            S_LD_WB: begin
                done_d     = 1'b1;
                done_op_d  = op_q;
                done_buf_d = bufsel_q;
            end
            S_ST_PF0: begin
                ren_d   = 1'b1;
                raddr_d = {bufsel_q, ROW_W'(1)};
            end
            S_ST_PF1: begin
                store_data_d = buf_rdata;
                sstore_d     = 1'b1;
                store_addr_d = addr_q;
            end
            S_ST: begin
                if (rvalid_q) next_d = buf_rdata;
                else          next_d = next_q;
                if (st_hit_s) begin
                    if (row_last_s) begin
                        sstore_d   = 1'b0;
                        done_d     = 1'b1;
                        done_op_d  = op_q;
                        done_buf_d = bufsel_q;
                    end else begin
                        store_data_d = next_val_s;
                        row_d        = row_q + ROW_W'(1);
                        if (row_p2_s < (ROW_W+1)'(ROWS)) begin
                            ren_d   = 1'b1;
                            raddr_d = {bufsel_q, row_p2_s[ROW_W-1:0]};
                        end else begin
                            ren_d = 1'b0;
                        end
                    end
                end else begin
                    store_data_d = store_data_q;
                end
            end
            S_DONE: begin
                done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE) || (|cnt_d);
    end

    // State, FIFO pointers and all registered outputs with synchronous reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            cnt_q        <= {(PTR_W+1){1'b0}};
            op_q         <= 1'b0;
            addr_q       <= 32'd0;
            bufsel_q     <= {BUF_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            next_q       <= 64'd0;
            rvalid_q     <= 1'b0;
            sload_q      <= 1'b0;
            sstore_q     <= 1'b0;
            load_addr_q  <= 32'd0;
            store_addr_q <= 32'd0;
            store_data_q <= 64'd0;
            wen_q        <= 1'b0;
            waddr_q      <= {(BUF_W+ROW_W){1'b0}};
            ren_q        <= 1'b0;
            raddr_q      <= {(BUF_W+ROW_W){1'b0}};
            done_q       <= 1'b0;
            done_op_q    <= 1'b0;
            done_buf_q   <= {BUF_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            bufsel_q     <= bufsel_d;
            row_q        <= row_d;
            next_q       <= next_d;
            rvalid_q     <= ren_q;
            sload_q      <= sload_d;
            sstore_q     <= sstore_d;
            load_addr_q  <= load_addr_d;
            store_addr_q <= store_addr_d;
            store_data_q <= store_data_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            ren_q        <= ren_d;
            raddr_q      <= raddr_d;
            done_q       <= done_d;
            done_op_q    <= done_op_d;
            done_buf_q   <= done_buf_d;
            busy_q       <= busy_d;
        end
    end

    assign sLoad      = sload_q;
    assign sStore     = sstore_q;
    assign load_addr  = load_addr_q;
    assign store_addr = store_addr_q;
    assign store_data = store_data_q;
    assign buf_wen    = wen_q;
    assign buf_waddr  = waddr_q;
    // Returned row is only valid in the strobe cycle, so it is passed straight through.
    assign buf_wdata  = wen_q ? load_data : 64'd0;
    assign buf_ren    = ren_q;
    assign buf_raddr  = raddr_q;
    assign done       = done_q;
    assign done_op    = done_op_q;
    assign done_buf   = done_buf_q;
    assign busy       = busy_q;

`ifdef SCRATCHPAD_SEQ_ROWCHECK_EN
    logic row_err_q, row_err_d;

    // Sticky error: wrong row index on a load hit, or a hit for the idle request
    always_comb begin
        row_err_d = row_err_q;
        if ((ld_hit_s && (sLoad_row != 2'(row_q))) ||
            (sLoad_hit && sstore_q && !sload_q) ||
            (sStore_hit && sload_q && !sstore_q)) begin
            row_err_d = 1'b1;
        end else begin
            row_err_d = row_err_q;
        end
    end

    // Row-error flag register, cleared only by reset
    always_ff @(posedge CLK) begin
        if (!nRST) row_err_q <= 1'b0;
        else       row_err_q <= row_err_d;
    end

    assign row_err = row_err_q;
`else
    logic unused_row_s;
    assign unused_row_s = ^sLoad_row;
`endif

endmodule

// File: tb/tb_scratchpad_seq.sv
// Directed testbench for scratchpad_seq: drives commands, plays the arbiter and
// models the matrix buffers, checking outputs against hand-computed values.
module tb_scratchpad_seq;

    logic        CLK, nRST;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_buf;
    logic        done, done_op, busy;
    logic [1:0]  done_buf;
    logic        sLoad, sStore;
    logic [31:0] load_addr, store_addr;
    logic [63:0] store_data;
    logic        sLoad_hit, sStore_hit;
    logic [63:0] load_data;
    logic [1:0]  sLoad_row;
    logic        buf_wen, buf_ren;
    logic [3:0]  buf_waddr, buf_raddr;
    logic [63:0] buf_wdata, buf_rdata;
`ifdef SCRATCHPAD_SEQ_ROWCHECK_EN
    logic        row_err;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] bmem [16];
    int          wr_count = 0;
    logic        d_op  [32];
    logic [1:0]  d_buf [32];
    int          d_n = 0;
    logic        prev_req = 1'b0;
    logic        seen_req = 1'b0;
    int          gap = 0;

    scratchpad_seq dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_buf(cmd_buf),
        .done(done), .done_op(done_op), .done_buf(done_buf), .busy(busy),
        .sLoad(sLoad), .sStore(sStore), .load_addr(load_addr), .store_addr(store_addr),
        .store_data(store_data), .sLoad_hit(sLoad_hit), .sStore_hit(sStore_hit),
        .load_data(load_data), .sLoad_row(sLoad_row),
        .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_ren(buf_ren), .buf_raddr(buf_raddr),
`ifdef SCRATCHPAD_SEQ_ROWCHECK_EN
        .row_err(row_err),
`endif
        .buf_rdata(buf_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Matrix buffer model: one-cycle read latency, write on strobe
    always @(posedge CLK) begin
        if (buf_wen) begin
            bmem[buf_waddr] <= buf_wdata;
            wr_count <= wr_count + 1;
        end
        if (buf_ren) buf_rdata <= bmem[buf_raddr];
    end

    // Record completions and check request spacing between commands
    always @(negedge CLK) begin
        if (done === 1'b1 && d_n < 32) begin
            d_op[d_n]  = done_op;
            d_buf[d_n] = done_buf;
            d_n++;
        end
        if ((sLoad | sStore) && !prev_req) begin
            if (seen_req) chk_eq("req_gap", 64'(gap >= 2), 64'd1);
            seen_req = 1'b1;
        end
        if (sLoad | sStore) gap = 0;
        else gap++;
        prev_req = sLoad | sStore;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input logic op, input logic [31:0] a, input logic [1:0] b);
        chk_eq("push_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_buf = b;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic serve_load(input logic [1:0] b, input logic [31:0] a, input logic [63:0] base,
                              input logic [63:0] inc, input int nrows, input int stall,
                              input logic [1:0] row0);
        int to = 0;
        while (!sLoad && to < 40) begin @(posedge CLK); #1; to++; end
        chk_eq("ld_req", sLoad, 1'b1);
        chk_eq("ld_addr", load_addr, a);
        for (int i = 0; i < nrows; i++) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge CLK); #1;
                chk_eq("ld_hold", {sLoad, buf_wen, load_addr}, {1'b1, 1'b0, a});
            end
            sLoad_hit = 1'b1;
            sLoad_row = (i == 0) ? row0 : 2'(i);
            @(posedge CLK); #1;
            sLoad_hit = 1'b0;
            load_data = base + inc * 64'(i);
            #1;
            chk_eq("ld_wen", buf_wen, 1'b1);
            chk_eq("ld_waddr", buf_waddr, {b, 2'(i)});
            chk_eq("ld_wdata", buf_wdata, base + inc * 64'(i));
            chk_eq("ld_sload", sLoad, (i == 3) ? 1'b0 : 1'b1);
        end
        if (nrows == 4) begin
            @(posedge CLK); #1;
            chk_eq("ld_done", {done, done_op, done_buf}, {1'b1, 1'b0, b});
            chk_eq("ld_wen_off", buf_wen, 1'b0);
            @(posedge CLK); #1;
            chk_eq("ld_done_pulse", done, 1'b0);
        end
    endtask

    task automatic serve_store(input logic [1:0] b, input logic [31:0] a, input logic [63:0] base,
                               input logic [63:0] inc, input int stall);
        int to = 0;
        while (!sStore && to < 40) begin @(posedge CLK); #1; to++; end
        chk_eq("st_req", sStore, 1'b1);
        chk_eq("st_addr", store_addr, a);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge CLK); #1;
                chk_eq("st_hold", {sStore, store_data}, {1'b1, base + inc * 64'(i)});
            end
            chk_eq("st_data", store_data, base + inc * 64'(i));
            sStore_hit = 1'b1;
            @(posedge CLK); #1;
            sStore_hit = 1'b0;
            if (i < 3) begin
                chk_eq("st_next", {sStore, store_data}, {1'b1, base + inc * 64'(i + 1)});
            end else begin
                chk_eq("st_done", {sStore, done, done_op, done_buf}, {1'b0, 1'b1, 1'b1, b});
            end
        end
        @(posedge CLK); #1;
        chk_eq("st_done_pulse", done, 1'b0);
    endtask

    initial begin
        logic [4:0] exp_ops;
        logic [9:0] exp_bufs;
        int start, snap_d, snap_w;

        nRST = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 32'd0; cmd_buf = 2'd0;
        sLoad_hit = 1'b0; sStore_hit = 1'b0; load_data = 64'd0; sLoad_row = 2'd0;
        buf_rdata = 64'd0;
        for (int i = 0; i < 16; i++) bmem[i] = 64'd0;
        for (int i = 0; i < 4; i++) bmem[{2'd1, 2'(i)}] = 64'hDEADBEEFCAFEFACE + 64'(i);

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk_eq("rst_ready", cmd_ready, 1'b0);
        chk_eq("rst_req", {sLoad, sStore, done, busy, buf_wen, buf_ren}, 6'd0);
        chk_eq("rst_addr", {load_addr, store_addr}, 64'd0);
        chk_eq("rst_sdata", store_data, 64'd0);
        chk_eq("rst_baddr", {buf_waddr, buf_raddr, buf_wdata[7:0]}, 16'd0);
`ifdef SCRATCHPAD_SEQ_ROWCHECK_EN
        chk_eq("rst_row_err", row_err, 1'b0);
`endif
        nRST = 1'b1;
        #1;
        chk_eq("ready_after_rst", cmd_ready, 1'b1);

        // single LOAD into buffer 2
        push_cmd(1'b0, 32'h0000_1000, 2'd2);
        serve_load(2'd2, 32'h0000_1000, 64'h9ABCDEF0_12345678, 64'h11111111_11111111, 4, 0, 2'd0);
        chk_eq("ld_idle", busy, 1'b0);
        for (int i = 0; i < 4; i++)
            chk_eq("ld_mem", bmem[{2'd2, 2'(i)}], 64'h9ABCDEF0_12345678 + 64'h11111111_11111111 * 64'(i));

        // single STORE from buffer 1
        push_cmd(1'b1, 32'h0000_2000, 2'd1);
        serve_store(2'd1, 32'h0000_2000, 64'hDEADBEEFCAFEFACE, 64'd1, 1);

        // back-to-back commands with a full FIFO
        start = d_n;
        push_cmd(1'b0, 32'h0000_3000, 2'd0);
        @(posedge CLK); #1;
        push_cmd(1'b1, 32'h0000_4000, 2'd1);
        push_cmd(1'b0, 32'h0000_5000, 2'd3);
        push_cmd(1'b1, 32'h0000_6000, 2'd2);
        push_cmd(1'b0, 32'h0000_7000, 2'd0);
        chk_eq("fifo_full_ready", cmd_ready, 1'b0);
        chk_eq("fifo_full_busy", busy, 1'b1);
        serve_load(2'd0, 32'h0000_3000, 64'h0101010101010101, 64'h1, 4, 1, 2'd0);
        serve_store(2'd1, 32'h0000_4000, 64'hDEADBEEFCAFEFACE, 64'd1, 2);
        serve_load(2'd3, 32'h0000_5000, 64'h5555000055550000, 64'h10, 4, 0, 2'd0);
        serve_store(2'd2, 32'h0000_6000, 64'h9ABCDEF0_12345678, 64'h11111111_11111111, 1);
        serve_load(2'd0, 32'h0000_7000, 64'h7777777700000000, 64'h3, 4, 2, 2'd0);
        chk_eq("b2b_count", 64'(d_n - start), 64'd5);
        exp_ops  = 5'b01010;
        exp_bufs = {2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
        for (int k = 0; k < 5; k++)
            chk_eq("b2b_order", {d_op[start + k], d_buf[start + k]}, {exp_ops[k], exp_bufs[2*k +: 2]});

        // reset in the middle of a LOAD
        push_cmd(1'b0, 32'h0000_8000, 2'd3);
        serve_load(2'd3, 32'h0000_8000, 64'hAAAA0000BBBB0000, 64'h1, 2, 0, 2'd0);
        push_cmd(1'b1, 32'h0000_9000, 2'd1);
        nRST = 1'b0;
        @(posedge CLK); #1;
        chk_eq("mid_rst_out", {sLoad, sStore, buf_wen, busy, cmd_ready}, 5'd0);
        snap_d = d_n;
        snap_w = wr_count;
        nRST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            chk_eq("mid_rst_quiet", {sLoad, sStore, buf_wen, busy}, 4'd0);
        end
        chk_eq("mid_rst_no_done", 64'(d_n), 64'(snap_d));
        chk_eq("mid_rst_no_wr", 64'(wr_count), 64'(snap_w));

        // arbiter stalls of five cycles per row
        snap_w = wr_count;
        push_cmd(1'b0, 32'h0000_A000, 2'd3);
        serve_load(2'd3, 32'h0000_A000, 64'h0102030405060708, 64'h1000, 4, 5, 2'd0);
        chk_eq("stall_wr_count", 64'(wr_count - snap_w), 64'd4);
        push_cmd(1'b1, 32'h0000_B000, 2'd3);
        serve_store(2'd3, 32'h0000_B000, 64'h0102030405060708, 64'h1000, 5);

`ifdef SCRATCHPAD_SEQ_ROWCHECK_EN
        // wrong row index on the first hit sets the sticky error
        chk_eq("row_err_clear", row_err, 1'b0);
        push_cmd(1'b0, 32'h0000_C000, 2'd0);
        serve_load(2'd0, 32'h0000_C000, 64'h1, 64'h1, 4, 0, 2'd2);
        chk_eq("row_err_set", row_err, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        chk_eq("row_err_sticky", row_err, 1'b1);
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        chk_eq("row_err_reset", row_err, 1'b0);
`endif

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
